master_port: RTL and testbench

MASTER_PORT -- requirements
Module: master_port

---
 rtl/master_port.sv | 227 ++++++++++++++++++++++
 tb/tb_master_port.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/master_port.sv
// master_port: serial bus master. Latches a read/write request, waits for
// slave_ready, shifts out an ADDR_W-bit address (and write data) LSB first,
// then for reads collects DATA_W bits from the slave with a timeout.
// Ports:
//   clk, reset       - clock, async active-high reset
//   req/mode/addr_in/wdata_in - request from the master device (mode 1=write)
//   rdata_out        - last successfully read word
//   busy/done/error  - status; error flags a read timeout, valid with done
//   read_en/write_en - one-cycle transfer-type strobes to the slave
//   slave_ready      - slave can accept a frame
//   master_valid, tx_address, tx_data - serial frame to the slave
//   slave_valid, rx_data - serial read data from the slave
//   master_ready     - master accepts read data
module master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mode,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              read_en,
  output logic              write_en,
  input  logic              slave_ready,
  output logic              master_valid,
  output logic              tx_address,
  output logic              tx_data,
  input  logic              slave_valid,
  input  logic              rx_data,
  output logic              master_ready
);

  localparam int AW_B = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int DW_B = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TO_B = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [AW_B-1:0] A_LAST = AW_B'(ADDR_W - 1);
  localparam logic [DW_B-1:0] R_LAST = DW_B'(DATA_W - 1);
  localparam logic [TO_B-1:0] T_LAST = TO_B'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SREADY,
    SEND,
    WAIT_RDATA,
    RECV,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // Write data is widened to the address length and zeroed for reads,
  // so tx_data can be indexed by the same counter as tx_address.
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic [AW_B-1:0]   acnt_q, acnt_d;
  logic [DW_B-1:0]   rcnt_q, rcnt_d;
  logic [TO_B-1:0]   tcnt_q, tcnt_d;
  logic [DATA_W-1:0] rxsh_q, rxsh_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              timeout_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic rd_en_q, rd_en_d;
  logic wr_en_q, wr_en_d;
  logic mv_q, mv_d;
  logic txa_q, txa_d;
  logic txd_q, txd_d;
  logic mr_q, mr_d;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    acnt_d    = acnt_q;
    rcnt_d    = rcnt_q;
    tcnt_d    = tcnt_q;
    rxsh_d    = rxsh_q;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          mode_d  = mode;
          addr_d  = addr_in;
          wdata_d = mode ? ADDR_W'(wdata_in) : '0;
          rd_en_d = ~mode;
          wr_en_d = mode;
          acnt_d  = '0;
          rcnt_d  = '0;
          tcnt_d  = '0;
          state_d = WAIT_SREADY;
        end
      end
      WAIT_SREADY: begin
        if (slave_ready) begin
          acnt_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (acnt_q == A_LAST) begin
          acnt_d  = '0;
          tcnt_d  = '0;
          state_d = mode_q ? DONE : WAIT_RDATA;
        end else begin
          acnt_d = acnt_q + 1'b1;
        end
      end
      WAIT_RDATA: begin
        if (slave_valid) begin
          rxsh_d = rxsh_q >> 1;
          rxsh_d[DATA_W-1] = rx_data;
          if (R_LAST == '0) begin
            rdata_d = rxsh_d;
            state_d = DONE;
          end else begin
            rcnt_d  = DW_B'(1);
            state_d = RECV;
          end
        end else if (tcnt_q == T_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RECV: begin
        // Counter stalls on cycles without slave_valid.
        if (slave_valid) begin
          rxsh_d = rxsh_q >> 1;
          rxsh_d[DATA_W-1] = rx_data;
          if (rcnt_q == R_LAST) begin
            rdata_d = rxsh_d;
            rcnt_d  = '0;
            state_d = DONE;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    error_d = timeout_d;
    mv_d    = (state_d == SEND);
    txa_d   = mv_d ? addr_d[acnt_d] : 1'b0;
    txd_d   = mv_d ? wdata_d[acnt_d] : 1'b0;
    mr_d    = (state_d == WAIT_RDATA) || (state_d == RECV);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      acnt_q  <= '0;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      rxsh_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      mv_q    <= 1'b0;
      txa_q   <= 1'b0;
      txd_q   <= 1'b0;
      mr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      acnt_q  <= acnt_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      rxsh_q  <= rxsh_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      mv_q    <= mv_d;
      txa_q   <= txa_d;
      txd_q   <= txd_d;
      mr_q    <= mr_d;
    end
  end

  assign rdata_out    = rdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign read_en      = rd_en_q;
  assign write_en     = wr_en_q;
  assign master_valid = mv_q;
  assign tx_address   = txa_q;
  assign tx_data      = txd_q;
  assign master_ready = mr_q;

endmodule

// File: tb/tb_master_port.sv
// tb_master_port: randomized self-checking bench for master_port.
// A cycle-level slave drives the bus; results are checked against arithmetic.
module tb_master_port;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 255;
  localparam int ZW = DW + 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          mode;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] wdata_in;
  logic [DW-1:0] rdata_out;
  logic          busy, done, error;
  logic          read_en, write_en;
  logic          slave_ready;
  logic          master_valid, tx_address, tx_data;
  logic          slave_valid, rx_data;
  logic          master_ready;

  master_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .mode(mode),
    .addr_in(addr_in), .wdata_in(wdata_in), .rdata_out(rdata_out),
    .busy(busy), .done(done), .error(error),
    .read_en(read_en), .write_en(write_en),
    .slave_ready(slave_ready), .master_valid(master_valid),
    .tx_address(tx_address), .tx_data(tx_data),
    .slave_valid(slave_valid), .rx_data(rx_data),
    .master_ready(master_ready)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  logic [DW-1:0] exp_rdata;

  // observations of the last transfer
  int o_rd, o_wr, o_stb_cyc;
  int o_mv_first, o_mv_last, o_mv_cnt;
  int o_mr_first, o_mr_cnt, o_busy_cnt;
  int o_done_cnt, o_done_cyc, o_last_v;
  bit o_err, o_err_stray, o_tx_bad, o_after_bad;
  logic [AW-1:0] o_addr, o_txd;
  logic [DW-1:0] o_rdata;

  function automatic logic [ZW-1:0] outs();
    return {rdata_out, busy, done, error, read_en, write_en,
            master_valid, tx_address, tx_data, master_ready};
  endfunction

  // Drives one transfer from a negedge and records what the bus did.
  task automatic run_xfer(input bit m, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int d,
                          input logic [DW-1:0] rd, input int lat,
                          input int gap, input bit never, input bit tog);
    int cyc, j, latc, gapc;
    o_rd = 0; o_wr = 0; o_stb_cyc = -1;
    o_mv_first = -1; o_mv_last = -1; o_mv_cnt = 0;
    o_mr_first = -1; o_mr_cnt = 0; o_busy_cnt = 0;
    o_done_cnt = 0; o_done_cyc = -1; o_last_v = -1;
    o_err = 0; o_err_stray = 0; o_tx_bad = 0; o_after_bad = 0;
    o_addr = '0; o_txd = '0; o_rdata = '0;
    req = 1'b1; mode = m; addr_in = a; wdata_in = wd;
    slave_ready = (d == 0); slave_valid = 1'b0; rx_data = 1'b0;
    cyc = 0; j = 0; latc = 0; gapc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (read_en) begin
        o_rd++;
        if (o_stb_cyc < 0) o_stb_cyc = cyc;
      end
      if (write_en) begin
        o_wr++;
        if (o_stb_cyc < 0) o_stb_cyc = cyc;
      end
      if (master_valid) begin
        if (o_mv_first < 0) o_mv_first = cyc;
        if (o_mv_cnt < AW) begin
          o_addr[o_mv_cnt] = tx_address;
          o_txd[o_mv_cnt]  = tx_data;
        end
        o_mv_cnt++;
        o_mv_last = cyc;
      end else if (tx_address || tx_data) begin
        o_tx_bad = 1;
      end
      if (master_ready) begin
        if (o_mr_first < 0) o_mr_first = cyc;
        o_mr_cnt++;
      end
      if (busy) o_busy_cnt++;
      if (error && !done) o_err_stray = 1;
      if (done) begin
        o_done_cnt++;
        o_done_cyc = cyc;
        o_err = error;
        o_rdata = rdata_out;
      end
      if (tog) begin
        req = 1'($urandom_range(0, 1));
        mode = 1'($urandom_range(0, 1));
        addr_in = AW'($urandom);
        wdata_in = DW'($urandom);
      end else begin
        req = 1'b0;
      end
      slave_ready = (cyc >= d);
      slave_valid = 1'b0;
      if (master_ready && !never && j < DW) begin
        if (j == 0 && latc < lat) latc++;
        else if (j == 4 && gapc < gap) gapc++;
        else begin
          slave_valid = 1'b1;
          rx_data = rd[j];
          j++;
          o_last_v = cyc;
        end
      end
      if (done) break;
      if (cyc > 800) begin
        n_chk++;
        $display("FAIL xfer_timeout no done within %0d cycles", cyc);
        break;
      end
    end
    req = 1'b0; slave_ready = 1'b0; slave_valid = 1'b0;
    @(negedge clk);
    if (busy || done || read_en || write_en || master_valid) o_after_bad = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 0; mode = 0; addr_in = '0; wdata_in = '0;
    slave_ready = 0; slave_valid = 0; rx_data = 0;
    @(negedge clk); @(negedge clk);
    n_chk++;
    if (outs() !== '0) $display("FAIL reset_outs got %h exp 0", outs());
    else n_pass++;
    reset = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic test_write();
    run_xfer(1'b1, 12'hA5C, 8'h3F, 0, 8'h00, 0, 0, 1'b0, 1'b0);
    n_chk++;
    if (o_wr !== 1 || o_rd !== 0 || o_stb_cyc !== 1)
      $display("FAIL wr_strobe got wr=%0d rd=%0d cyc=%0d exp 1 0 1", o_wr, o_rd, o_stb_cyc);
    else n_pass++;
    n_chk++;
    if (o_addr !== 12'hA5C || o_mv_cnt !== AW)
      $display("FAIL wr_addr got %h/%0d exp a5c/12", o_addr, o_mv_cnt);
    else n_pass++;
    n_chk++;
    if (o_txd !== 12'h03F) $display("FAIL wr_data got %h exp 03f", o_txd);
    else n_pass++;
    n_chk++;
    if (o_done_cnt !== 1 || o_err !== 1'b0 || o_done_cyc !== o_mv_last + 1)
      $display("FAIL wr_done got n=%0d err=%0b cyc=%0d exp 1 0 %0d",
               o_done_cnt, o_err, o_done_cyc, o_mv_last + 1);
    else n_pass++;
  endtask

  task automatic test_read();
    run_xfer(1'b0, 12'h001, 8'h00, 0, 8'hC3, 2, 3, 1'b0, 1'b0);
    exp_rdata = 8'hC3;
    n_chk++;
    if (o_rd !== 1 || o_wr !== 0) $display("FAIL rd_strobe got rd=%0d wr=%0d exp 1 0", o_rd, o_wr);
    else n_pass++;
    n_chk++;
    if (o_addr !== 12'h001 || o_txd !== '0) $display("FAIL rd_frame got %h/%h exp 001/000", o_addr, o_txd);
    else n_pass++;
    n_chk++;
    if (o_rdata !== exp_rdata || o_err !== 1'b0 || o_done_cnt !== 1)
      $display("FAIL rd_result got %h err=%0b n=%0d exp %h 0 1", o_rdata, o_err, o_done_cnt, exp_rdata);
    else n_pass++;
    n_chk++;
    if (o_mr_first !== o_mv_last + 1 || o_done_cyc !== o_last_v + 1)
      $display("FAIL rd_timing got mr=%0d done=%0d exp %0d %0d",
               o_mr_first, o_done_cyc, o_mv_last + 1, o_last_v + 1);
    else n_pass++;
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, AW'($urandom), 8'h00, 0, 8'hFF, 0, 0, 1'b1, 1'b0);
    n_chk++;
    if (o_done_cyc !== o_mr_first + TO || o_mr_cnt !== TO)
      $display("FAIL to_timing got done=%0d mr=%0d exp %0d %0d",
               o_done_cyc, o_mr_cnt, o_mr_first + TO, TO);
    else n_pass++;
    n_chk++;
    if (o_err !== 1'b1 || o_done_cnt !== 1 || o_err_stray)
      $display("FAIL to_error got err=%0b n=%0d stray=%0b exp 1 1 0", o_err, o_done_cnt, o_err_stray);
    else n_pass++;
    n_chk++;
    if (rdata_out !== exp_rdata) $display("FAIL to_rdata got %h exp %h", rdata_out, exp_rdata);
    else n_pass++;
  endtask

  task automatic test_sready_wait();
    run_xfer(1'b1, AW'($urandom), DW'($urandom), 11, 8'h00, 0, 0, 1'b0, 1'b0);
    n_chk++;
    if (o_mv_first !== 12 || o_mv_cnt !== AW || o_mv_last !== 12 + AW - 1)
      $display("FAIL sready_send got first=%0d cnt=%0d last=%0d exp 12 12 23",
               o_mv_first, o_mv_cnt, o_mv_last);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k, cnt;
    logic [DW-1:0] r;
    req = 1'b1; mode = 1'b1; addr_in = AW'($urandom); wdata_in = DW'($urandom);
    slave_ready = 1'b1;
    cnt = 0; k = 0;
    while (cnt < 6 && k < 100) begin
      @(negedge clk);
      req = 1'b0;
      k++;
      if (master_valid) cnt++;
    end
    n_chk++;
    if (cnt !== 6) $display("FAIL rstmid_reach got %0d bits exp 6", cnt);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (outs() !== '0) $display("FAIL rstmid_outs got %h exp 0", outs());
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    slave_ready = 1'b0;
    exp_rdata = '0;
    r = DW'($urandom);
    run_xfer(1'b0, AW'($urandom), 8'h00, 0, r, 1, 0, 1'b0, 1'b0);
    exp_rdata = r;
    n_chk++;
    if (o_stb_cyc !== 1 || o_rd !== 1) $display("FAIL rstmid_accept got cyc=%0d rd=%0d exp 1 1", o_stb_cyc, o_rd);
    else n_pass++;
    n_chk++;
    if (o_rdata !== exp_rdata || o_done_cnt !== 1 || o_err !== 1'b0)
      $display("FAIL rstmid_read got %h n=%0d err=%0b exp %h 1 0", o_rdata, o_done_cnt, o_err, exp_rdata);
    else n_pass++;
  endtask

  task automatic test_req_toggle();
    logic [AW-1:0] a;
    a = AW'($urandom);
    run_xfer(1'b1, a, DW'($urandom), 3, 8'h00, 0, 0, 1'b0, 1'b1);
    n_chk++;
    if (o_wr + o_rd !== 1 || o_done_cnt !== 1 || o_after_bad)
      $display("FAIL toggle got strobes=%0d done=%0d after=%0b exp 1 1 0",
               o_wr + o_rd, o_done_cnt, o_after_bad);
    else n_pass++;
    n_chk++;
    if (o_addr !== a) $display("FAIL toggle_addr got %h exp %h", o_addr, a);
    else n_pass++;
  endtask

  task automatic test_random();
    bit m;
    int d, first;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rd;
    logic [AW-1:0] exp_txd;
    for (int it = 0; it < 12; it++) begin
      m = 1'($urandom_range(0, 1));
      a = AW'($urandom);
      wd = DW'($urandom);
      rd = DW'($urandom);
      d = $urandom_range(0, 4);
      run_xfer(m, a, wd, d, rd, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
      if (!m) exp_rdata = rd;
      exp_txd = m ? AW'(wd) : '0;
      first = ((d > 1) ? d : 1) + 1;
      n_chk++;
      if (o_stb_cyc !== 1 || o_wr !== int'(m) || o_rd !== int'(!m))
        $display("FAIL rnd%0d_strobe got cyc=%0d wr=%0d rd=%0d mode=%0b", it, o_stb_cyc, o_wr, o_rd, m);
      else n_pass++;
      n_chk++;
      if (o_mv_first !== first || o_mv_last !== first + AW - 1 || o_mv_cnt !== AW)
        $display("FAIL rnd%0d_send got %0d..%0d n=%0d exp %0d..%0d", it,
                 o_mv_first, o_mv_last, o_mv_cnt, first, first + AW - 1);
      else n_pass++;
      n_chk++;
      if (o_addr !== a || o_txd !== exp_txd || o_tx_bad)
        $display("FAIL rnd%0d_frame got %h/%h bad=%0b exp %h/%h", it, o_addr, o_txd, o_tx_bad, a, exp_txd);
      else n_pass++;
      n_chk++;
      if (m ? (o_done_cyc !== o_mv_last + 1 || o_mr_cnt !== 0)
            : (o_done_cyc !== o_last_v + 1 || o_mr_first !== o_mv_last + 1 ||
               o_mr_cnt !== o_done_cyc - o_mr_first))
        $display("FAIL rnd%0d_timing got done=%0d mr=%0d/%0d", it, o_done_cyc, o_mr_first, o_mr_cnt);
      else n_pass++;
      n_chk++;
      if (o_done_cnt !== 1 || o_err !== 1'b0 || o_err_stray || o_rdata !== exp_rdata)
        $display("FAIL rnd%0d_result got n=%0d err=%0b rdata=%h exp 1 0 %h", it,
                 o_done_cnt, o_err, o_rdata, exp_rdata);
      else n_pass++;
      n_chk++;
      if (o_busy_cnt !== o_done_cyc || o_after_bad)
        $display("FAIL rnd%0d_busy got %0d after=%0b exp %0d 0", it, o_busy_cnt, o_after_bad, o_done_cyc);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_sready_wait();
    test_reset_mid();
    test_req_toggle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
